// File: rtl/wb_bram_initiator.sv
// Wishbone classic slave driving a single-port 16-bit BRAM (byte enables, 1-cycle read).
// Define WB_BRAM_BURST_EN to enable incrementing read bursts (cti=3'b010).
module wb_bram_initiator #(
  parameter int AW        = 15,
  parameter int MEM_WORDS = 32768
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [1:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [15:0]   wb_dat_i,
  input  logic [2:0]    wb_cti_i,
  output logic [15:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [1:0]    bram_we,
  output logic [AW-1:0] bram_adr,
  output logic [15:0]   bram_dat_o,
  input  logic [15:0]   bram_dat_i
);

  typedef enum logic [1:0] {IDLE, ACK, ERR} state_t;

  localparam logic [AW:0] MEM_LIM = (AW+1)'(MEM_WORDS);

  state_t state_q, state_d;
  logic   ack_q, ack_d;
  logic   err_q, err_d;
  logic   req, oor;
  logic   burst_go;

  assign req = wb_cyc_i & wb_stb_i;
  assign oor = ({1'b0, wb_adr_i} >= MEM_LIM);

`ifdef WB_BRAM_BURST_EN
  logic [AW-1:0] adr_nxt;
  // Lookahead wraps naturally at 2^AW; a lookahead beyond the memory ends the burst.
  assign adr_nxt  = wb_adr_i + {{(AW-1){1'b0}}, 1'b1};
  assign burst_go = req & ~wb_we_i & (wb_cti_i == 3'b010) & ({1'b0, adr_nxt} < MEM_LIM);
`else
  logic unused_cti;
  assign unused_cti = ^wb_cti_i;
  assign burst_go   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bram_adr = wb_adr_i;
    bram_we  = 2'b00;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (oor) begin
            state_d = ERR;
          end else begin
            state_d = ACK;
            bram_we = wb_sel_i & {2{wb_we_i}};
          end
        end
      end
      ACK: begin
        state_d = IDLE;
        if (burst_go) begin
          state_d = ACK;
`ifdef WB_BRAM_BURST_EN
          bram_adr = adr_nxt;
`endif
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The FSM sits in IDLE during reset; keep a live request from writing.
    if (wb_rst_i) bram_we = 2'b00;
    ack_d = (state_d == ACK);
    err_d = (state_d == ERR);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb_ack_o   = ack_q & req;
  assign wb_err_o   = err_q & req;
  assign wb_dat_o   = bram_dat_i;
  assign bram_dat_o = wb_dat_i;

endmodule

// File: tb/tb_wb_bram_initiator.sv
// Directed bench for wb_bram_initiator with a 1024-word BRAM model; table vectors plus
// hand sequences for reset, dropped strobe, error duration and bursts.
module tb_wb_bram_initiator;

  localparam int AW = 15;
  localparam int MW = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [AW-1:0] adr = '0;
  logic [15:0]   dat = 16'h0;
  logic [2:0]    cti = 3'b000;
  logic [15:0]   dat_o;
  logic          ack, err;
  logic [1:0]    bwe;
  logic [AW-1:0] badr;
  logic [15:0]   bdat_o;
  logic [15:0]   bdat_i;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_bram_initiator #(.AW(AW), .MEM_WORDS(MW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(dat), .wb_cti_i(cti),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .bram_we(bwe), .bram_adr(badr), .bram_dat_o(bdat_o), .bram_dat_i(bdat_i)
  );

  // BRAM model: byte-enabled synchronous write, registered read (read-before-write).
  logic [15:0] mem [0:MW-1];
  always @(posedge clk) begin
    if (bwe[0]) mem[badr[9:0]][7:0]  <= bdat_o[7:0];
    if (bwe[1]) mem[badr[9:0]][15:8] <= bdat_o[15:8];
    bdat_i <= mem[badr[9:0]];
  end

  typedef struct {
    logic          we;
    logic [1:0]    sel;
    logic [AW-1:0] adr;
    logic [15:0]   dat;
    logic [1:0]    exp_we;
    logic          exp_err;
    logic [15:0]   exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                               input logic [15:0] d, input logic [1:0] ew, input logic ee,
                               input logic [15:0] er);
    vec_t v;
    v.we = w; v.sel = s; v.adr = a; v.dat = d; v.exp_we = ew; v.exp_err = ee; v.exp_rd = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [AW-1:0] a,
                       input logic [15:0] d, input logic [2:0] c);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d; cti = c;
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 2'b00; cti = 3'b000;
  endtask

  task automatic access(input vec_t v, input int idx);
    @(posedge clk); #1;
    drive(v.we, v.sel, v.adr, v.dat, 3'b000);
    @(negedge clk);
    chk($sformatf("v%0d bram_we", idx), 32'(bwe), 32'(v.exp_we));
    chk($sformatf("v%0d early ack", idx), 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk($sformatf("v%0d ack", idx), 32'(ack), 32'(!v.exp_err));
    chk($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
    if (!v.we && !v.exp_err) chk($sformatf("v%0d rdata", idx), 32'(dat_o), 32'(v.exp_rd));
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs.push_back(mkv(1, 2'b11, 15'h0010, 16'hBEEF, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h0010, 16'h0,    2'b00, 0, 16'hBEEF));
    vecs.push_back(mkv(1, 2'b10, 15'h0010, 16'h1234, 2'b10, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h0010, 16'h0,    2'b00, 0, 16'h12EF));
    vecs.push_back(mkv(1, 2'b01, 15'h0010, 16'h5678, 2'b01, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b00, 15'h0010, 16'h0,    2'b00, 0, 16'h1278));
    vecs.push_back(mkv(1, 2'b11, 15'h0011, 16'hC3C3, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(1, 2'b00, 15'h0011, 16'hFFFF, 2'b00, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h0011, 16'h0,    2'b00, 0, 16'hC3C3));
    vecs.push_back(mkv(1, 2'b11, 15'h03FF, 16'hA5A5, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h03FF, 16'h0,    2'b00, 0, 16'hA5A5));
    vecs.push_back(mkv(0, 2'b11, 15'h0400, 16'h0,    2'b00, 1, 16'h0));
    vecs.push_back(mkv(1, 2'b11, 15'h0400, 16'hDEAD, 2'b00, 1, 16'h0));
    vecs.push_back(mkv(1, 2'b11, 15'h7FFF, 16'hDEAD, 2'b00, 1, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h0000, 16'h0,    2'b00, 0, 16'h0000));
    vecs.push_back(mkv(1, 2'b11, 15'h0100, 16'h0001, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(1, 2'b11, 15'h0101, 16'h0002, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(1, 2'b11, 15'h0102, 16'h0003, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(1, 2'b11, 15'h0103, 16'h0004, 2'b11, 0, 16'h0));
    vecs.push_back(mkv(0, 2'b11, 15'h0103, 16'h0,    2'b00, 0, 16'h0004));

    // Reset held with a busy bus: no responses, no writes.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom), 2'($urandom), 15'($urandom_range(0, 2047)), 16'($urandom), 3'b000);
      @(negedge clk);
      chk("rst ack", 32'(ack), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst bram_we", 32'(bwe), 32'd0);
    end
    @(posedge clk); #1;
    idle_bus();
    rst = 1'b0;
    // Address 0 is written here so the later read of it has a known value.
    access(mkv(1, 2'b11, 15'h0000, 16'h0000, 2'b11, 0, 16'h0), 99);

    foreach (vecs[i]) access(vecs[i], i);

    // Master drops strobe during the ACK of a write, then issues a read.
    @(posedge clk); #1;
    drive(1'b1, 2'b11, 15'h0020, 16'h1111, 3'b000);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    chk("drop ack hidden", 32'(ack), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 2'b11, 15'h0020, 16'h0, 3'b000);
    @(negedge clk);
    chk("drop no stale ack", 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drop 2nd ack", 32'(ack), 32'd1);
    chk("drop 2nd data", 32'(dat_o), 32'h1111);
    @(posedge clk); @(negedge clk);
    chk("drop single ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    idle_bus();

    // Error lasts exactly one cycle while the request stays up.
    @(posedge clk); #1;
    drive(1'b0, 2'b11, 15'h0400, 16'h0, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("err first", 32'(err), 32'd1);
    chk("err no ack", 32'(ack), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("err one cycle", 32'(err), 32'd0);
    @(posedge clk); #1;
    idle_bus();

`ifdef WB_BRAM_BURST_EN
    // 4-beat incrementing read burst over the preloaded 1..4.
    @(posedge clk); #1;
    drive(1'b0, 2'b11, 15'h0100, 16'h0, 3'b010);
    @(negedge clk);
    chk("burst wait", 32'(ack), 32'd0);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (b > 0) begin
        adr = 15'h0100 + 15'(b);
        cti = (b == 3) ? 3'b111 : 3'b010;
      end
      @(negedge clk);
      chk($sformatf("burst ack %0d", b), 32'(ack), 32'd1);
      chk($sformatf("burst data %0d", b), 32'(dat_o), 32'(b + 1));
    end
    @(posedge clk); @(negedge clk);
    chk("burst end", 32'(ack), 32'd0);
    @(posedge clk); #1;
    idle_bus();
`else
    // Without bursts, cti=010 is still a single access.
    @(posedge clk); #1;
    drive(1'b0, 2'b11, 15'h0100, 16'h0, 3'b010);
    @(posedge clk); @(negedge clk);
    chk("cti ack", 32'(ack), 32'd1);
    chk("cti data", 32'(dat_o), 32'h0001);
    @(posedge clk); @(negedge clk);
    chk("cti no burst", 32'(ack), 32'd0);
    @(posedge clk); #1;
    idle_bus();
`endif

    // Reset asserted mid-ACK drops the response at once.
    @(posedge clk); #1;
    drive(1'b1, 2'b11, 15'h0030, 16'h7777, 3'b000);
    @(posedge clk); @(negedge clk);
    chk("mid ack before", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid ack", 32'(ack), 32'd0);
    chk("mid err", 32'(err), 32'd0);
    chk("mid bram_we", 32'(bwe), 32'd0);
    @(posedge clk); #1;
    idle_bus();
    rst = 1'b0;
    access(mkv(0, 2'b11, 15'h0030, 16'h0, 2'b00, 0, 16'h7777), 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
